id_stage_fwd: RTL and testbench
===============================

# id_stage_fwd

Parametrised decode / operand-fetch stage for the 16-bit five-stage pipeline. It sits between IF and EX and latches `ex_ir`, `reg_a`, `reg_b` and `smdr` once per `exec` step. Operands come from the register file or are forwarded from EX, MEM and WB. Compared with the previous ID stage it adds three things: generic data width and register count, a load-use interlock that inserts one bubble with a `stall` handshake to IF, and a saturating stall counter.

## Interface
- `DATA_W`, 16: datapath width; must be ≥ 16.
- `NREG`, 8: number of general registers. Register fields are 3 bits, so only `gr[0..7]` are addressable.
- `CNT_W`, 16: width of the stall counter.

Ports (name, direction, width, meaning):
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `state` input 1: pipeline step enable; the stage updates only when `state == `exec`.
- `id_ir` input 16: instruction in ID.
- `mem_ir` input 16: instruction in MEM.
- `wb_ir` input 16: instruction in WB.
- `jump` input 1: branch taken in EX; flush request.
- `alu_out` input DATA_W: EX result.
- `reg_c` input DATA_W: MEM ALU result.
- `d_datain` input DATA_W: MEM load data.
- `reg_c1` input DATA_W: WB result.
- `gr_flat` input NREG*DATA_W: register file; `gr[i]` = `gr_flat[i*DATA_W +: DATA_W]`.
- `ex_ir` output 16: instruction issued to EX.
- `reg_a` output DATA_W: EX operand A.
- `reg_b` output DATA_W: EX operand B.
- `smdr` output DATA_W: store data.
- `stall` output 1: combinational; hold IF/`id_ir` this step.
- `stall_cnt` output CNT_W: number of bubbles inserted, saturating.

## Operation
- Field names: op = `[15:11]`, r1 = `[10:8]`, r2 = `[6:4]`, r3 = `[2:0]`.
- Writer set W = {LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA}. LOAD also writes r1, but only from MEM onward.
- Register reads by instruction class:
  - `reg_a` = r1 for BZ, BNZ, BN, BNN, BC, BNC, JMPR, ADDI, SUBI, LDIH.
  - `reg_a` = r2 for LOAD, STORE, ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR, SLL, SRL, SLA, SRA.
  - `reg_b` = r3 for ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR.
  - `smdr` = r1 for STORE.
- Immediates for `reg_b`, zero-extended to DATA_W:
  - LOAD, STORE and shifts: `id_ir[3:0]`.
  - Branches, JMPR, ADDI, SUBI: `id_ir[7:0]`.
  - LDIH: `id_ir[7:0]` placed at bits [15:8], all other bits 0.
- Forwarding priority for each read register s, highest first:
  1. `ex_ir` in W with r1 == s → `alu_out`.
  2. `mem_ir` in W with r1 == s → `reg_c`.
  3. `mem_ir` LOAD with r1 == s → `d_datain`.
  4. `wb_ir` in W∪{LOAD} with r1 == s → `reg_c1`.
  5. Otherwise `gr[s]`.
- Load-use interlock: `stall` = `exec` && !`jump` && `id_ir` op != JUMP && `ex_ir` op == LOAD && `ex_ir` r1 equals any register `id_ir` reads.
- Step actions when `exec`, first matching row wins:
  1. `jump` → `ex_ir` ← 0. Operands hold.
  2. `id_ir` op == JUMP → `ex_ir` ← 0. Operands hold.
  3. `stall` → `ex_ir` ← 0, operands hold, `stall_cnt` increments and saturates at all-ones.
  4. Otherwise → `ex_ir` ← `id_ir`. Operands that the class uses are loaded; unused operands hold.
- When not `exec`: all registers hold and `stall` = 0.

## Timing
- Reset (asynchronous, at any time including mid-stall): `ex_ir`, `reg_a`, `reg_b`, `smdr` and `stall_cnt` all go to 0; `stall` goes to 0 combinationally.
- Latency: one clock edge from `id_ir` to `ex_ir` and the operands.
- Forwarding paths are combinational, sampled at the same edge.
- A load-use hazard costs exactly one bubble. On the next step `ex_ir` is 0 and the LOAD is in MEM, so the dependent instruction takes `d_datain` and `stall` drops.
- When `jump` and `stall` would coincide, `jump` wins: `stall` stays 0 and the counter does not change.
- `stall_cnt` holds at 2^CNT_W − 1.

## Configuration
- `ID_EX_FWD_EN` defined:
  - EX→ID forwarding from `alu_out` is present, as described above.
- `ID_EX_FWD_EN` undefined:
  - The `alu_out` path is removed.
  - `ex_ir` in W with r1 matching a read register also asserts `stall`, with the same bubble and counter behaviour as a load-use hazard.
  - The instruction then picks up the value from `reg_c` on the next step.

## Test plan
- Reset then step ADD r1,r2,r3 with `gr2`=5, `gr3`=7 → `reg_a`=5, `reg_b`=7, `ex_ir`=`id_ir`.
- ADDI r2 issued, then ADD r1,r2,r3 with `alu_out`=0x1234 → `reg_a`=0x1234 when `ID_EX_FWD_EN` is defined. Without the macro: `stall`=1, one bubble (`ex_ir`=0), then `reg_a`=`reg_c`.
- LOAD r4 in EX, `id_ir`=SUB r1,r4,r5 → `stall`=1, `ex_ir`=0, `stall_cnt`=1. Next step `reg_a`=`d_datain`=0xBEEF.
- STORE r3,r2,4 with WB writing r3, `reg_c1`=0x00AA → `smdr`=0x00AA, `reg_b`=4.
- Load-use hazard and `jump`=1 in the same step → `ex_ir`=0, `stall`=0, `stall_cnt` unchanged.
- LDIH r1,0x5A → `reg_b`=0x5A00. Reset asserted mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/id_stage_fwd.sv
// Decode/operand-fetch stage: forwards from EX/MEM/WB, inserts one bubble on load-use (and EX-writer hazards
// unless ID_EX_FWD_EN is defined, which enables the alu_out forwarding path). Latency 1 edge; stall holds IF.
module id_stage_fwd #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     state,
  input  logic [15:0]              id_ir,
  input  logic [15:0]              mem_ir,
  input  logic [15:0]              wb_ir,
  input  logic                     jump,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic [DATA_W-1:0]        reg_c,
  input  logic [DATA_W-1:0]        d_datain,
  input  logic [DATA_W-1:0]        reg_c1,
  input  logic [NREG*DATA_W-1:0]   gr_flat,
  output logic [15:0]              ex_ir,
  output logic [DATA_W-1:0]        reg_a,
  output logic [DATA_W-1:0]        reg_b,
  output logic [DATA_W-1:0]        smdr,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam logic       EXEC = 1'b1;
  localparam logic [4:0] LOAD = 5'b00010, STORE = 5'b00011, LDIH = 5'b10000,
                         ADD  = 5'b01000, ADDI  = 5'b01001, ADDC = 5'b10001,
                         SUB  = 5'b01010, SUBI  = 5'b01011, SUBC = 5'b10010,
                         CMP  = 5'b01100, AND   = 5'b01101, OR   = 5'b01110,
                         XOR  = 5'b01111, SLL   = 5'b00100, SLA  = 5'b00101,
                         SRL  = 5'b00110, SRA   = 5'b00111, JUMP = 5'b11000,
                         JMPR = 5'b11001, BZ    = 5'b11010, BNZ  = 5'b11011,
                         BN   = 5'b11100, BNN   = 5'b11101, BC   = 5'b11110,
                         BNC  = 5'b11111;

  function automatic logic is_w(input logic [4:0] op);
    return op inside {LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA};
  endfunction

  logic [DATA_W-1:0] gr [8];
  for (genvar g = 0; g < 8; g++) begin : g_gr
    if (g < NREG) begin : g_present
      assign gr[g] = gr_flat[g*DATA_W +: DATA_W];
    end else begin : g_absent
      assign gr[g] = '0;
    end
  end

  logic [15:0]       ex_ir_q, ex_ir_d;
  logic [DATA_W-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d, smdr_q, smdr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [4:0] id_op, ex_op, mem_op, wb_op;
  logic [2:0] id_r1, id_r2, id_r3, a_src, ex_r1, mem_r1, wb_r1;
  assign id_op  = id_ir[15:11];
  assign id_r1  = id_ir[10:8];
  assign id_r2  = id_ir[6:4];
  assign id_r3  = id_ir[2:0];
  assign ex_op  = ex_ir_q[15:11];
  assign ex_r1  = ex_ir_q[10:8];
  assign mem_op = mem_ir[15:11];
  assign mem_r1 = mem_ir[10:8];
  assign wb_op  = wb_ir[15:11];
  assign wb_r1  = wb_ir[10:8];

  logic a_r1, a_r2, b_r3, b_i4, b_i8, b_hi, use_s;
  assign a_r1  = id_op inside {BZ, BNZ, BN, BNN, BC, BNC, JMPR, ADDI, SUBI, LDIH};
  assign a_r2  = id_op inside {LOAD, STORE, ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR, SLL, SRL, SLA, SRA};
  assign b_r3  = id_op inside {ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR};
  assign b_i4  = id_op inside {LOAD, STORE, SLL, SRL, SLA, SRA};
  assign b_i8  = id_op inside {BZ, BNZ, BN, BNN, BC, BNC, JMPR, ADDI, SUBI};
  assign b_hi  = (id_op == LDIH);
  assign use_s = (id_op == STORE);
  assign a_src = a_r1 ? id_r1 : id_r2;

  // Lowest priority source first; later matches override earlier ones.
  function automatic logic [DATA_W-1:0] fwd(input logic [2:0] s);
    logic [DATA_W-1:0] v;
    v = gr[s];
    if ((is_w(wb_op) || wb_op == LOAD) && wb_r1 == s) v = reg_c1;
    if (mem_op == LOAD && mem_r1 == s)                 v = d_datain;
    if (is_w(mem_op) && mem_r1 == s)                   v = reg_c;
`ifdef ID_EX_FWD_EN
    if (is_w(ex_op) && ex_r1 == s)                     v = alu_out;
`endif
    return v;
  endfunction

  logic rd_hit, hz_src, stall_w;
  assign rd_hit = ((a_r1 || a_r2) && a_src == ex_r1) ||
                  (b_r3 && id_r3 == ex_r1) ||
                  (use_s && id_r1 == ex_r1);
`ifdef ID_EX_FWD_EN
  assign hz_src = (ex_op == LOAD);
`else
  // Without the EX bypass, an EX writer result is only reachable one step later via reg_c.
  assign hz_src = (ex_op == LOAD) || is_w(ex_op);
  logic unused_alu_out;
  assign unused_alu_out = ^alu_out;
`endif
  assign stall_w = reset && (state == EXEC) && !jump && (id_op != JUMP) && hz_src && rd_hit;

  logic unused_ir_bits;
  assign unused_ir_bits = ^{mem_ir[7:0], wb_ir[7:0]};

  always_comb begin
    ex_ir_d = ex_ir_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    smdr_d  = smdr_q;
    cnt_d   = cnt_q;
    if (state == EXEC) begin
      if (jump || id_op == JUMP) begin
        ex_ir_d = '0;
      end else if (stall_w) begin
        ex_ir_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ex_ir_d = id_ir;
        if (a_r1 || a_r2) reg_a_d = fwd(a_src);
        if (b_r3)         reg_b_d = fwd(id_r3);
        else if (b_i4)    reg_b_d = DATA_W'(id_ir[3:0]);
        else if (b_i8)    reg_b_d = DATA_W'(id_ir[7:0]);
        else if (b_hi)    reg_b_d = DATA_W'({id_ir[7:0], 8'h00});
        if (use_s)        smdr_d  = fwd(id_r1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_ir_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      smdr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ex_ir_q <= ex_ir_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      smdr_q  <= smdr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_ir     = ex_ir_q;
  assign reg_a     = reg_a_q;
  assign reg_b     = reg_b_q;
  assign smdr      = smdr_q;
  assign stall     = stall_w;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed vector bench for id_stage_fwd; expectations follow the ID_EX_FWD_EN setting of the build.
module tb_id_stage_fwd;

  localparam int DW = 16;
  localparam int CW = 2;
`ifdef ID_EX_FWD_EN
  localparam int C = 0;
`else
  localparam int C = 1;
`endif

  logic          clock = 1'b0;
  logic          reset, state, jump;
  logic [15:0]   id_ir, mem_ir, wb_ir;
  logic [DW-1:0] alu_out, reg_c, d_datain, reg_c1;
  logic [8*DW-1:0] gr_flat;
  logic [15:0]   ex_ir;
  logic [DW-1:0] reg_a, reg_b, smdr;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  always #5 clock = ~clock;

  id_stage_fwd #(.DATA_W(DW), .NREG(8), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .state(state), .id_ir(id_ir), .mem_ir(mem_ir),
    .wb_ir(wb_ir), .jump(jump), .alu_out(alu_out), .reg_c(reg_c), .d_datain(d_datain),
    .reg_c1(reg_c1), .gr_flat(gr_flat), .ex_ir(ex_ir), .reg_a(reg_a), .reg_b(reg_b),
    .smdr(smdr), .stall(stall), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        st;
    logic [15:0] id, mem, wb;
    logic        jmp;
    logic [15:0] alu;
    logic        stl;
    logic [15:0] ex, a, b, sm;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [15:0] id, mem, wb, input logic jmp,
                     input logic [15:0] alu, input logic stl, input logic [15:0] ex, a, b, sm,
                     input int cnt);
    vec_t v;
    v.st = st; v.id = id; v.mem = mem; v.wb = wb; v.jmp = jmp; v.alu = alu;
    v.stl = stl; v.ex = ex; v.a = a; v.b = b; v.sm = sm; v.cnt = 2'(cnt);
    vecs.push_back(v);
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clock);
    state = v.st; id_ir = v.id; mem_ir = v.mem; wb_ir = v.wb; jump = v.jmp; alu_out = v.alu;
    #1 chk({nm, " stall"}, 32'(stall), 32'(v.stl));
    @(posedge clock);
    #1;
    chk({nm, " ex_ir"}, 32'(ex_ir), 32'(v.ex));
    chk({nm, " reg_a"}, 32'(reg_a), 32'(v.a));
    chk({nm, " reg_b"}, 32'(reg_b), 32'(v.b));
    chk({nm, " smdr"}, 32'(smdr), 32'(v.sm));
    chk({nm, " stall_cnt"}, 32'(stall_cnt), 32'(v.cnt));
  endtask

  initial begin
    vec_t v;
    int exp_cnt;
    reset = 1'b0; state = 1'b1; jump = 1'b0;
    id_ir = '0; mem_ir = '0; wb_ir = '0;
    alu_out = 16'hA1A1; reg_c = 16'hC0C0; d_datain = 16'hBEEF; reg_c1 = 16'h00AA;
    gr_flat = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h0007, 16'h0005, 16'h1111, 16'h0000};

    //   st id       mem      wb       jmp alu       stl ex       a        b        smdr     cnt
    add(1, 16'h4123, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h4123, 16'h0005, 16'h0007, 16'h0000, 0);
    add(1, 16'h4A03, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h4A03, 16'h0005, 16'h0003, 16'h0000, 0);
`ifdef ID_EX_FWD_EN
    add(1, 16'h4123, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h4123, 16'h1234, 16'h0007, 16'h0000, 0);
`else
    add(1, 16'h4123, 16'h0000, 16'h0000, 0, 16'h1234, 1, 16'h0000, 16'h0005, 16'h0003, 16'h0000, 1);
`endif
    add(1, 16'h4123, 16'h4A03, 16'h0000, 0, 16'hA1A1, 0, 16'h4123, 16'hC0C0, 16'h0007, 16'h0000, C);
    add(1, 16'h1421, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h1421, 16'h0005, 16'h0001, 16'h0000, C);
    add(1, 16'h5145, 16'h0000, 16'h0000, 0, 16'hA1A1, 1, 16'h0000, 16'h0005, 16'h0001, 16'h0000, C+1);
    add(1, 16'h5145, 16'h1421, 16'h0000, 0, 16'hA1A1, 0, 16'h5145, 16'hBEEF, 16'h5555, 16'h0000, C+1);
    add(1, 16'h1B24, 16'h0000, 16'h4323, 0, 16'hA1A1, 0, 16'h1B24, 16'h0005, 16'h0004, 16'h00AA, C+1);
    add(1, 16'h1421, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h1421, 16'h0005, 16'h0001, 16'h00AA, C+1);
    add(1, 16'h5145, 16'h0000, 16'h0000, 1, 16'hA1A1, 0, 16'h0000, 16'h0005, 16'h0001, 16'h00AA, C+1);
    add(1, 16'h815A, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h815A, 16'h1111, 16'h5A00, 16'h00AA, C+1);
    add(1, 16'hC000, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h0000, 16'h1111, 16'h5A00, 16'h00AA, C+1);
    add(1, 16'h1421, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h1421, 16'h0005, 16'h0001, 16'h00AA, C+1);
    add(0, 16'h5145, 16'h0000, 16'h0000, 0, 16'hA1A1, 0, 16'h1421, 16'h0005, 16'h0001, 16'h00AA, C+1);
    add(1, 16'h5145, 16'h0000, 16'h0000, 0, 16'hA1A1, 1, 16'h0000, 16'h0005, 16'h0001, 16'h00AA, C+2);

    repeat (2) @(posedge clock);
    #1;
    chk("reset ex_ir", 32'(ex_ir), 32'h0);
    chk("reset reg_a", 32'(reg_a), 32'h0);
    chk("reset reg_b", 32'(reg_b), 32'h0);
    chk("reset smdr", 32'(smdr), 32'h0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) apply($sformatf("row%0d", i + 1), vecs[i]);

    // Repeated load-use pairs drive the 2-bit counter into saturation.
    exp_cnt = C + 2;
    for (int k = 0; k < 3; k++) begin
      v = vecs[12];
      v.cnt = 2'(exp_cnt);
      apply($sformatf("sat%0d load", k), v);
      exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      v = vecs[14];
      v.cnt = 2'(exp_cnt);
      apply($sformatf("sat%0d use", k), v);
    end

    // Asynchronous reset in the middle of a stall.
    apply("pre_rst load", '{st: 1, id: 16'h1421, mem: 16'h0, wb: 16'h0, jmp: 0, alu: 16'hA1A1,
                            stl: 0, ex: 16'h1421, a: 16'h0005, b: 16'h0001, sm: 16'h00AA, cnt: 2'd3});
    @(negedge clock);
    id_ir = 16'h5145;
    #1 chk("midstall stall", 32'(stall), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst stall", 32'(stall), 32'h0);
    chk("midrst ex_ir", 32'(ex_ir), 32'h0);
    chk("midrst reg_a", 32'(reg_a), 32'h0);
    chk("midrst reg_b", 32'(reg_b), 32'h0);
    chk("midrst smdr", 32'(smdr), 32'h0);
    chk("midrst stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
